// File: rtl/divider.sv
// divider -- multicycle restoring integer divider for the MIPS div/divu path.
// One quotient bit is resolved per clock; a request completes 33 edges after
// the start edge, or one edge after it when the divisor is zero.
//
// Build option: define DIVIDER_SIGNED_EN for two's-complement (div) results;
// leave it undefined for unsigned (divu) results.
//
// Ports:
//   clk          : CPU clock, rising edge
//   reset        : synchronous, active-high; clears operands, results and FSM
//   dloadab      : capture a_in/b_in into the operand registers (ignored while busy)
//   div          : start request, sampled in IDLE
//   a_in, b_in   : dividend / divisor
//   div_low_out  : quotient  (to LO)
//   div_high_out : remainder (to HI)
//   divzero      : level flag, divisor was zero on the last accepted start
//   div_busy     : high while iterations are in progress
//   div_done     : one-cycle completion pulse
module divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dloadab,
  input  logic             div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] div_low_out,
  output logic [WIDTH-1:0] div_high_out,
  output logic             divzero,
  output logic             div_busy,
  output logic             div_done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ZERO
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [CW-1:0]    r_cnt;

  logic             w_idle;
  logic [WIDTH-1:0] w_opa;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_last;
  logic [WIDTH-1:0] w_fix_q;
  logic [WIDTH-1:0] w_fix_r;

  assign w_idle = (r_state == S_IDLE);

  // Operands being loaded this cycle bypass the operand registers on a start.
  assign w_opa = dloadab ? a_in : r_a;
  assign w_opb = dloadab ? b_in : r_b;

`ifdef DIVIDER_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;

  // 0x80000000 has no positive counterpart but its unsigned magnitude is exact.
  assign w_mag_a = w_opa[WIDTH-1] ? -w_opa : w_opa;
  assign w_mag_b = w_opb[WIDTH-1] ? -w_opb : w_opb;
  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;
`else
  assign w_mag_a = w_opa;
  assign w_mag_b = w_opb;
  assign w_fix_q = r_quo;
  assign w_fix_r = r_rem;
`endif

  // Shifted partial remainder can reach WIDTH+1 bits; a set MSB of the
  // difference means the trial subtract borrowed.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_dvsr};
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (div) w_state_nxt = (w_opb == '0) ? S_ZERO : S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      S_ZERO: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a          <= '0;
      r_b          <= '0;
      r_rem        <= '0;
      r_quo        <= '0;
      r_dvsr       <= '0;
      r_cnt        <= '0;
      div_low_out  <= '0;
      div_high_out <= '0;
      divzero      <= 1'b0;
      div_busy     <= 1'b0;
      div_done     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      r_neg_q      <= 1'b0;
      r_neg_r      <= 1'b0;
`endif
    end else begin
      div_done <= 1'b0;
      if (w_idle && dloadab) begin
        r_a <= a_in;
        r_b <= b_in;
      end
      case (r_state)
        S_IDLE: begin
          if (div) begin
            divzero <= 1'b0;
            r_rem   <= '0;
            r_quo   <= w_mag_a;
            r_dvsr  <= w_mag_b;
            r_cnt   <= '0;
`ifdef DIVIDER_SIGNED_EN
            r_neg_q <= w_opa[WIDTH-1] ^ w_opb[WIDTH-1];
            r_neg_r <= w_opa[WIDTH-1];
`endif
          end
        end
        S_RUN: begin
          div_busy <= 1'b1;
          r_rem    <= w_diff[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_quo    <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
          r_cnt    <= r_cnt + 1'b1;
        end
        S_FIX: begin
          div_low_out  <= w_fix_q;
          div_high_out <= w_fix_r;
          div_done     <= 1'b1;
          div_busy     <= 1'b0;
        end
        S_ZERO: begin
          divzero  <= 1'b1;
          div_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
module tb_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        dloadab;
  logic        div;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [31:0] div_low_out;
  logic [31:0] div_high_out;
  logic        divzero;
  logic        div_busy;
  logic        div_done;

  int total = 0;
  int bad   = 0;

  divider #(.WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .dloadab      (dloadab),
    .div          (div),
    .a_in         (a_in),
    .b_in         (b_in),
    .div_low_out  (div_low_out),
    .div_high_out (div_high_out),
    .divzero      (divzero),
    .div_busy     (div_busy),
    .div_done     (div_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the division rules.
  task automatic calc(input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] q, output logic [31:0] r);
`ifdef DIVIDER_SIGNED_EN
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    q  = lq[31:0];
    r  = lr[31:0];
`else
    q = a / b;
    r = a % b;
`endif
  endtask

  // Behavioural model: tracks operands and counts edges since the start.
  bit          m_valid = 0;
  logic [31:0] m_ra = '0, m_rb = '0, m_opa = '0, m_opb = '0;
  int          m_edge = 0;
  logic [31:0] e_lo = '0, e_hi = '0;
  bit          e_zero = 0, e_busy = 0, e_done = 0;

  always @(posedge clk) begin
    logic [31:0] q, r;
    m_valid = 1;
    if (reset) begin
      m_ra = '0; m_rb = '0; m_edge = 0;
      e_lo = '0; e_hi = '0; e_zero = 0; e_busy = 0; e_done = 0;
    end else begin
      e_done = 0;
      if (m_edge == 0) begin
        m_opa = dloadab ? a_in : m_ra;
        m_opb = dloadab ? b_in : m_rb;
        if (dloadab) begin m_ra = a_in; m_rb = b_in; end
        if (div) begin
          e_zero = 0;
          m_edge = 1;
        end
      end else if (m_opb == 0) begin
        e_zero = 1; e_done = 1; m_edge = 0;
      end else if (m_edge <= 32) begin
        e_busy = 1; m_edge++;
      end else begin
        calc(m_opa, m_opb, q, r);
        e_lo = q; e_hi = r; e_done = 1; e_busy = 0; m_edge = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("lo",      div_low_out,  e_lo);
      chk("hi",      div_high_out, e_hi);
      chk("divzero", {31'b0, divzero},  {31'b0, e_zero});
      chk("busy",    {31'b0, div_busy}, {31'b0, e_busy});
      chk("done",    {31'b0, div_done}, {31'b0, e_done});
    end
  end

  // Called at a negedge; returns at the negedge after the start edge.
  task automatic start_op(input logic ld, input logic [31:0] a, input logic [31:0] b);
    dloadab = ld; div = 1'b1; a_in = a; b_in = b;
    @(negedge clk);
    dloadab = 1'b0; div = 1'b0;
  endtask

  // Returns at the negedge on which div_done is high.
  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (div_done) return;
      if (div_busy) busy_cnt++;
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL wait_done timeout actual=no_done required=done at %0t", $time);
  endtask

  initial begin
    int bc, dn;
    logic [31:0] a, b;
    reset = 1'b1; dloadab = 1'b1; div = 1'b1; a_in = 32'd100; b_in = 32'd7;
    repeat (3) @(negedge clk);
    chk("rst_lo", div_low_out, 32'd0);
    chk("rst_busy", {31'b0, div_busy}, 32'd0);
    chk("rst_done", {31'b0, div_done}, 32'd0);
    reset = 1'b0; dloadab = 1'b0; div = 1'b0;
    @(negedge clk);

    // Operand registers were cleared: a bare start sees divisor 0.
    start_op(1'b0, 32'd55, 32'd3);
    wait_done(bc);
    chk("rst_operands_zero", {31'b0, divzero}, 32'd1);
    @(negedge clk);

    start_op(1'b1, 32'd100, 32'd7);
    wait_done(bc);
    chk("100/7 lo", div_low_out, 32'd14);
    chk("100/7 hi", div_high_out, 32'd2);
    chk("100/7 busy cycles", bc, 32'd32);
    chk("100/7 divzero", {31'b0, divzero}, 32'd0);
    @(negedge clk);

    start_op(1'b1, 32'hFFFFFFF9, 32'd2);
    wait_done(bc);
`ifdef DIVIDER_SIGNED_EN
    chk("-7/2 lo", div_low_out, 32'hFFFFFFFD);
    chk("-7/2 hi", div_high_out, 32'hFFFFFFFF);
`else
    chk("-7/2 lo", div_low_out, 32'h7FFFFFFC);
    chk("-7/2 hi", div_high_out, 32'd1);
`endif
    @(negedge clk);

    start_op(1'b1, 32'd9, 32'd4);
    wait_done(bc);
    @(negedge clk);
    dloadab = 1'b1; a_in = 32'd5; b_in = 32'd0;
    @(negedge clk);
    dloadab = 1'b0;
    start_op(1'b0, 32'd77, 32'd77);
    wait_done(bc);
    chk("zero divzero", {31'b0, divzero}, 32'd1);
    chk("zero lo held", div_low_out, 32'd2);
    chk("zero hi held", div_high_out, 32'd1);
    chk("zero busy cycles", bc, 32'd0);
    start_op(1'b1, 32'd100, 32'd7);
    chk("divzero cleared", {31'b0, divzero}, 32'd0);
    wait_done(bc);

    // Requests during RUN are ignored, operands kept.
    @(negedge clk);
    start_op(1'b1, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    start_op(1'b1, 32'd12345, 32'd11);
    wait_done(bc);
    chk("midrun lo", div_low_out, 32'd333);
    chk("midrun hi", div_high_out, 32'd1);
    @(negedge clk);
    start_op(1'b0, 32'd0, 32'd0);
    wait_done(bc);
    chk("kept operands lo", div_low_out, 32'd333);

    // Back-to-back start in the done cycle.
    start_op(1'b1, 32'hFFFFFFFF, 32'd1);
    wait_done(bc);
    chk("b2b lo", div_low_out, 32'hFFFFFFFF);
    chk("b2b busy cycles", bc, 32'd32);
`ifdef DIVIDER_SIGNED_EN
    chk("b2b hi", div_high_out, 32'd0);
`endif

    start_op(1'b1, 32'h80000000, 32'hFFFFFFFF);
    wait_done(bc);
`ifdef DIVIDER_SIGNED_EN
    chk("min/-1 lo", div_low_out, 32'h80000000);
    chk("min/-1 hi", div_high_out, 32'd0);
`else
    chk("min/max lo", div_low_out, 32'd0);
    chk("min/max hi", div_high_out, 32'h80000000);
`endif
    chk("min/-1 divzero", {31'b0, divzero}, 32'd0);

    // Reset mid-RUN abandons the operation.
    start_op(1'b1, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst lo", div_low_out, 32'd0);
    chk("midrst busy", {31'b0, div_busy}, 32'd0);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (div_done) dn++;
    end
    chk("midrst no done", dn, 32'd0);

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      bit ld, noise;
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2:    b = $urandom_range(1, 15);
        3:       b = 32'hFFFFFFFF;
        4:       begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom;
      endcase
      ld = ($urandom_range(0, 3) != 0);
      noise = ld && (b != 0) && ($urandom_range(0, 2) == 0);
      if (!ld) begin
        dloadab = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        dloadab = 1'b0;
        start_op(1'b0, $urandom, $urandom);
      end else begin
        start_op(1'b1, a, b);
      end
      if (noise) begin
        repeat ($urandom_range(2, 20)) @(negedge clk);
        start_op(1'b1, $urandom, $urandom);
      end
      wait_done(bc);
      if (!noise) chk("rand busy cycles", bc, (b == 0) ? 32'd0 : 32'd32);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/divider.md
# divider

Multicycle 32-bit integer divider serving the MIPS datapath's `div` instruction. It is the responder for the control unit's `dloadab`/`div` request signals and returns `divzero` plus the quotient/remainder pair that the HI/LO muxes route into the `high`/`low` registers. It uses one restoring-division iteration per cycle, is held in its idle state by synchronous reset, and reports completion with a one-cycle `div_done` pulse.

## Interface
- `WIDTH`, 32, operand and result width. Only 32 is supported by the datapath.
- `clk` in 1: the CPU clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `dloadab` in 1: captures `a_in`/`b_in` into the operand registers.
- `div` in 1: start request, sampled on the rising edge.
- `a_in` in 32: dividend, taken from register A.
- `b_in` in 32: divisor, taken from register B.
- `div_low_out` out 32: quotient (goes to LO).
- `div_high_out` out 32: remainder (goes to HI).
- `divzero` out 1: divide-by-zero flag to the control unit.
- `div_busy` out 1: high while an operation is in progress.
- `div_done` out 1: one-cycle completion pulse.

## Operation
- All outputs reset to 0. Reset also clears the operand registers and returns the FSM to IDLE.
- Operand capture:
  - When `dloadab=1` and the block is not busy, the operand registers load `a_in`/`b_in`.
  - While busy, `dloadab` is ignored.
- Start: `div=1` in IDLE starts an operation on the operand registers.
  - If `dloadab=1` in the same cycle, the values being loaded are used (bypass).
  - `div` while busy is ignored; there is no queuing and no abort.
- FSM states:
  - IDLE: waits for `div`.
    - Divisor 0 → ZERO.
    - Otherwise → RUN with count=0.
  - RUN: on each edge, shift {rem,quo} left by 1 and trial-subtract the divisor.
    - If the result is ≥0, keep it and set the quotient LSB to 1.
    - Count increments; after 32 iterations → FIX.
  - FIX: apply sign correction, register the results on `div_low_out`/`div_high_out`, pulse `div_done`, → IDLE.
  - ZERO: set `divzero=1`, pulse `div_done`, leave `div_high_out`/`div_low_out` unchanged, → IDLE.
- `divzero` is a level signal. It stays high until the next accepted start or reset, and clears on the start edge.
- Results hold until the next non-zero-divisor operation completes.
- Arithmetic is internally on magnitudes. Remainder and quotient registers are 32 bits each; the trial subtract is 33 bits wide.
- Reset mid-operation: the next edge with `reset=1` abandons the operation and all outputs become 0.

## Timing
- Start edge S: `div` is sampled. `div_busy=1` from S+1 until the edge that completes the operation.
- Normal operation:
  - RUN covers edges S+1..S+32; FIX is at edge S+33.
  - `div_done=1` and the results are valid during the cycle after edge S+33, so latency is 33 edges from start.
  - `div_busy` falls at the same edge `div_done` rises.
- Divide by zero: `divzero=1`, `div_done=1`, `div_busy=0` after edge S+1.
- A new start is accepted in the same cycle that `div_done` is high, i.e. back-to-back operations are allowed.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `DIVIDER_SIGNED_EN` defined (signed, MIPS `div` semantics):
  - Operands are two's complement and the divider works on their magnitudes.
  - The quotient is negated when the operand signs differ, so it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0, with no flag raised.
- Not defined (unsigned, `divu` semantics): operands are unsigned, and FIX only registers the results.
- Latency is identical in both builds.

## Test plan
- Reset with `div=1` and `dloadab=1` held → all outputs 0 and no start while reset is high; after release, the FSM is in IDLE.
- `dloadab`+`div` with a=100, b=7 → after 33 edges, `div_done` pulses with LO=14 and HI=2, `div_busy` high for exactly 32 cycles, and `divzero=0`.
- Signed build, a=−7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). Unsigned build, same inputs → LO=0x7FFFFFFC, HI=1.
- Load a=5, b=0, then `div` with LO/HI preloaded from a previous 9/4 → `divzero=1` and `div_done` one edge after start; LO=2 and HI=1 unchanged. The next valid start clears `divzero`.
- `div` and `dloadab` pulsed mid-RUN with new operands → ignored; the original result completes on schedule and the operand registers are unchanged.
- Back-to-back: second start (a=0xFFFFFFFF, b=1) asserted in the `div_done` cycle → second `div_done` 33 edges later with LO=0xFFFFFFFF (unsigned build) or LO=0xFFFFFFFF, HI=0 (signed build). Reset asserted mid-RUN → outputs 0 and no `div_done`.
